pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, flush-to-bubble and an optional two-entry skid buffer. It is the successor to the fixed-width inter-stage latches and sits between any two CPU pipeline stages: ID/EX, EX/MEM or MEM/WB. Control bits are zeroed whenever the stage holds no valid instruction, so downstream stages see a harmless bubble. A saturating counter records back-pressure cycles for performance analysis.

## Interface
- CTRL_W, 4: width of control field (e.g. WB+M bits); zeroed on bubble/flush.
- DATA_W, 69: width of payload (e.g. ALU result 32 + store data 32 + dest reg 5).
- SKID, 0: 0 = single register, combinational ready path; 1 = two-entry skid buffer, registered in_ready.
- STAT_W, 16: width of stall counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage accepts input this cycle.
- in_ctrl  input  CTRL_W  upstream control bits.
- in_data  input  DATA_W  upstream payload.
- flush  input  1  discard all held and offered entries.
- out_valid  output  1  stage holds a valid instruction.
- out_ready  input  1  downstream accepts this cycle.
- out_ctrl  output  CTRL_W  control bits; 0 whenever out_valid=0.
- out_data  output  DATA_W  payload; don't-care when out_valid=0.
- stall_cnt  output  STAT_W  saturating count of back-pressure cycles.

## Operation
- Accept = in_valid & in_ready & ~flush. Deliver = out_valid & out_ready.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1 (SKID=1: skid entry empty).
- Priority per cycle: rst > flush > normal handshake.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - On accept: the output register loads in_ctrl/in_data and out_valid=1.
  - On deliver without accept: out_valid=0 and out_ctrl=0.
  - Otherwise the register holds.
- SKID=1: three states, EMPTY, ONE, FULL. in_ready = ~skid_valid (registered).
  - EMPTY: accept -> ONE, output loaded.
  - ONE, accept & deliver: output reloaded, stays ONE.
  - ONE, accept only: entry goes to skid -> FULL.
  - ONE, deliver only -> EMPTY.
  - FULL: in_ready=0. On deliver, skid moves to output -> ONE. Otherwise hold.
- Ordering is strict FIFO; no entry is ever duplicated or dropped except by flush.
- flush:
  - Next cycle: out_valid=0, out_ctrl=0, skid emptied (state EMPTY), in_ready=1.
  - An input offered in the flush cycle is not accepted, even if in_ready=1.
  - out_data may retain its old value.
- stall_cnt: +1 each cycle with out_valid & ~out_ready. Saturates at 2^STAT_W-1. Cleared only by rst; flush does not clear it.

## Timing
- Latency 1 cycle: an entry accepted at edge N appears on out_* after edge N, through the skid only when stalled.
- Throughput 1 entry/cycle in both modes under continuous out_ready=1.
- SKID=0: combinational path out_ready -> in_ready. SKID=1: in_ready, out_valid, out_ctrl and out_data are all driven directly from flops.
- After a stall releases in SKID=1, in_ready rises one cycle after the deliver that emptied the skid.
- rst or flush mid-stall: the state is cleared at the next edge regardless of out_ready.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_ctrl=4'hF -> out_valid=0, out_ctrl=0, stall_cnt=0, in_ready=1 the cycle after release.
- Streaming, both SKID values: feed data 1..10 back-to-back with out_ready=1 -> out_data 1..10 on consecutive cycles, 1-cycle latency, no gaps.
- Back-pressure with SKID=1: stream 1..5, drop out_ready for 3 cycles at item 2 -> in_ready falls after the skid fills; output order is 1..5 with no loss; stall_cnt=3.
- Back-pressure with SKID=0: same stimulus -> in_ready=0 in the same cycles out_ready=0; out_data held at 2; order preserved.
- Flush during FULL (SKID=1) with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the offered entry never appears; stall_cnt unchanged.
- Saturation with STAT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with a valid/ready handshake,
// flush-to-bubble and an optional two-entry skid buffer.
// Control bits are forced to zero whenever the stage holds no valid entry,
// so downstream stages only ever see a harmless bubble.
// A saturating counter records back-pressure cycles.
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69,
  parameter int SKID   = 0,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [STAT_W-1:0] stall_cnt
);

  // Occupancy of the skid variant; FULL means the skid entry is occupied.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic              accept_s;
  logic              deliver_s;
  logic              in_ready_s;
  logic              out_valid_r;
  logic [CTRL_W-1:0] out_ctrl_r;
  logic [DATA_W-1:0] out_data_r;
  logic [STAT_W-1:0] stall_cnt_r;

  // A flush cycle never accepts, even if the stage reports ready.
  assign accept_s  = in_valid & in_ready_s & ~flush;
  assign deliver_s = out_valid_r & out_ready;

  generate
    if (SKID == 0) begin : g_single
      // Ready is combinational: a full register can still accept when it is
      // being drained in the same cycle.
      assign in_ready_s = ~out_valid_r | out_ready;

      // Single output register: load on accept, turn into a bubble on deliver.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_r <= 1'b0;
          out_ctrl_r  <= {CTRL_W{1'b0}};
          out_data_r  <= {DATA_W{1'b0}};
        end else if (flush) begin
          out_valid_r <= 1'b0;
          out_ctrl_r  <= {CTRL_W{1'b0}};
        end else if (accept_s) begin
          out_valid_r <= 1'b1;
          out_ctrl_r  <= in_ctrl;
          out_data_r  <= in_data;
        end else if (deliver_s) begin
          out_valid_r <= 1'b0;
          out_ctrl_r  <= {CTRL_W{1'b0}};
        end
      end
    end else begin : g_skid
      state_t            state_r;
      logic              in_ready_r;
      logic [CTRL_W-1:0] skid_ctrl_r;
      logic [DATA_W-1:0] skid_data_r;

      // Ready comes straight from a flop, so no combinational path crosses
      // the stage; the skid entry absorbs the one entry that arrives while
      // the downstream stall is still being noticed.
      assign in_ready_s = in_ready_r;

      // Skid controller: output register plus one overflow entry, FIFO order.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_r     <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_ctrl_r  <= {CTRL_W{1'b0}};
          out_data_r  <= {DATA_W{1'b0}};
          skid_ctrl_r <= {CTRL_W{1'b0}};
          skid_data_r <= {DATA_W{1'b0}};
        end else if (flush) begin
          state_r     <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_ctrl_r  <= {CTRL_W{1'b0}};
        end else begin
          case (state_r)
            EMPTY: begin
              if (accept_s) begin
                out_valid_r <= 1'b1;
                out_ctrl_r  <= in_ctrl;
                out_data_r  <= in_data;
                state_r     <= ONE;
              end
            end
            ONE: begin
              if (accept_s && deliver_s) begin
                out_ctrl_r <= in_ctrl;
                out_data_r <= in_data;
              end else if (accept_s) begin
                skid_ctrl_r <= in_ctrl;
                skid_data_r <= in_data;
                in_ready_r  <= 1'b0;
                state_r     <= FULL;
              end else if (deliver_s) begin
                out_valid_r <= 1'b0;
                out_ctrl_r  <= {CTRL_W{1'b0}};
                state_r     <= EMPTY;
              end
            end
            FULL: begin
              if (deliver_s) begin
                out_valid_r <= 1'b1;
                out_ctrl_r  <= skid_ctrl_r;
                out_data_r  <= skid_data_r;
                in_ready_r  <= 1'b1;
                state_r     <= ONE;
              end
            end
            default: begin
              state_r     <= EMPTY;
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
              out_ctrl_r  <= {CTRL_W{1'b0}};
            end
          endcase
        end
      end
    end
  endgenerate

  // Back-pressure counter: counts held-but-not-taken cycles, saturates, and
  // survives flush so performance data is not lost on pipeline redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {STAT_W{1'b0}};
    end else if (out_valid_r && !out_ready && (stall_cnt_r != {STAT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + STAT_W'(1'b1);
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_ctrl  = out_ctrl_r;
  assign out_data  = out_data_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: instance a uses the single-register
// variant (STAT_W=16), instance b the skid variant with a 4-bit counter.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [3:0]  a_in_ctrl, a_out_ctrl;
  logic [68:0] a_in_data, a_out_data;
  logic [15:0] a_stall_cnt;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [3:0]  b_in_ctrl, b_out_ctrl;
  logic [68:0] b_in_data, b_out_data;
  logic [3:0]  b_stall_cnt;

  int errors;
  int checks;

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .SKID(0), .STAT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .stall_cnt(a_stall_cnt)
  );

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .SKID(1), .STAT_W(4)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .stall_cnt(b_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    a_in_valid = 1'b0; a_in_ctrl = 4'hF; a_in_data = 69'd0; a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_ctrl = 4'hF; b_in_data = 69'd0; b_flush = 1'b0; b_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_ctrl = 4'hF; a_in_data = 69'h123;
    b_in_valid = 1'b1; b_in_ctrl = 4'hF; b_in_data = 69'h123;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got=%0d exp=0", a_out_valid); end
    checks++; if (a_out_ctrl !== 4'h0) begin errors++; $display("FAIL rst_a_ctrl got=%0h exp=0", a_out_ctrl); end
    checks++; if (a_out_data !== 69'd0) begin errors++; $display("FAIL rst_a_data got=%0h exp=0", a_out_data); end
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_a_stall got=%0d exp=0", a_stall_cnt); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready got=%0d exp=1", a_in_ready); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got=%0d exp=0", b_out_valid); end
    checks++; if (b_out_ctrl !== 4'h0) begin errors++; $display("FAIL rst_b_ctrl got=%0h exp=0", b_out_ctrl); end
    checks++; if (b_out_data !== 69'd0) begin errors++; $display("FAIL rst_b_data got=%0h exp=0", b_out_data); end
    checks++; if (b_stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_b_stall got=%0d exp=0", b_stall_cnt); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready got=%0d exp=1", b_in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    logic [73:0] exp_v;
    do_reset();
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      if (i <= 10) begin
        a_in_valid = 1'b1; a_in_data = 69'(i); a_in_ctrl = 4'(i);
        b_in_valid = 1'b1; b_in_data = 69'(i); b_in_ctrl = 4'(i);
      end else begin
        a_in_valid = 1'b0; a_in_ctrl = 4'hF;
        b_in_valid = 1'b0; b_in_ctrl = 4'hF;
      end
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_a_ready cyc=%0d got=%0d exp=1", i, a_in_ready); end
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL stream_b_ready cyc=%0d got=%0d exp=1", i, b_in_ready); end
      if (i == 1) begin
        checks++; if ({a_out_valid, a_out_ctrl} !== 5'h00) begin errors++; $display("FAIL stream_a_first got=%0d/%0h exp=0/0", a_out_valid, a_out_ctrl); end
        checks++; if ({b_out_valid, b_out_ctrl} !== 5'h00) begin errors++; $display("FAIL stream_b_first got=%0d/%0h exp=0/0", b_out_valid, b_out_ctrl); end
      end else begin
        exp_v = {1'b1, 4'(i - 1), 69'(i - 1)};
        checks++; if ({a_out_valid, a_out_ctrl, a_out_data} !== exp_v) begin errors++; $display("FAIL stream_a_out cyc=%0d got=%0d/%0h/%0d exp=1/%0h/%0d", i, a_out_valid, a_out_ctrl, a_out_data, 4'(i - 1), i - 1); end
        checks++; if ({b_out_valid, b_out_ctrl, b_out_data} !== exp_v) begin errors++; $display("FAIL stream_b_out cyc=%0d got=%0d/%0h/%0d exp=1/%0h/%0d", i, b_out_valid, b_out_ctrl, b_out_data, 4'(i - 1), i - 1); end
      end
      @(posedge clk); #1;
    end
    checks++; if ({a_out_valid, a_out_ctrl} !== 5'h00) begin errors++; $display("FAIL stream_a_drain got=%0d/%0h exp=0/0", a_out_valid, a_out_ctrl); end
    checks++; if ({b_out_valid, b_out_ctrl} !== 5'h00) begin errors++; $display("FAIL stream_b_drain got=%0d/%0h exp=0/0", b_out_valid, b_out_ctrl); end
  endtask

  task automatic test_backpressure();
    bit or_t[10]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit ov_t[10]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit rdya_t[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit rdyb_t[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int od_t[10]   = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 0};
    int nxt_a;
    int nxt_b;
    logic [73:0] exp_v;
    do_reset();
    nxt_a = 1;
    nxt_b = 1;
    for (int c = 0; c < 10; c++) begin
      a_in_valid = (nxt_a <= 5); a_in_data = 69'(nxt_a); a_in_ctrl = 4'(nxt_a); a_out_ready = or_t[c];
      b_in_valid = (nxt_b <= 5); b_in_data = 69'(nxt_b); b_in_ctrl = 4'(nxt_b); b_out_ready = or_t[c];
      #1;
      checks++; if (a_in_ready !== rdya_t[c]) begin errors++; $display("FAIL bp_a_ready cyc=%0d got=%0d exp=%0d", c + 1, a_in_ready, rdya_t[c]); end
      checks++; if (b_in_ready !== rdyb_t[c]) begin errors++; $display("FAIL bp_b_ready cyc=%0d got=%0d exp=%0d", c + 1, b_in_ready, rdyb_t[c]); end
      if (ov_t[c]) begin
        exp_v = {1'b1, 4'(od_t[c]), 69'(od_t[c])};
        checks++; if ({a_out_valid, a_out_ctrl, a_out_data} !== exp_v) begin errors++; $display("FAIL bp_a_out cyc=%0d got=%0d/%0h/%0d exp=1/%0h/%0d", c + 1, a_out_valid, a_out_ctrl, a_out_data, 4'(od_t[c]), od_t[c]); end
        checks++; if ({b_out_valid, b_out_ctrl, b_out_data} !== exp_v) begin errors++; $display("FAIL bp_b_out cyc=%0d got=%0d/%0h/%0d exp=1/%0h/%0d", c + 1, b_out_valid, b_out_ctrl, b_out_data, 4'(od_t[c]), od_t[c]); end
      end else begin
        checks++; if ({a_out_valid, a_out_ctrl} !== 5'h00) begin errors++; $display("FAIL bp_a_bubble cyc=%0d got=%0d/%0h exp=0/0", c + 1, a_out_valid, a_out_ctrl); end
        checks++; if ({b_out_valid, b_out_ctrl} !== 5'h00) begin errors++; $display("FAIL bp_b_bubble cyc=%0d got=%0d/%0h exp=0/0", c + 1, b_out_valid, b_out_ctrl); end
      end
      if (rdya_t[c] && nxt_a <= 5) nxt_a++;
      if (rdyb_t[c] && nxt_b <= 5) nxt_b++;
      @(posedge clk); #1;
    end
    checks++; if (a_stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_a_stall got=%0d exp=3", a_stall_cnt); end
    checks++; if (b_stall_cnt !== 4'd3) begin errors++; $display("FAIL bp_b_stall got=%0d exp=3", b_stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    // Cycle 1: first entry, downstream stalled.
    a_in_valid = 1'b1; a_in_data = 69'd1; a_in_ctrl = 4'd1; a_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 69'd1; b_in_ctrl = 4'd1; b_out_ready = 1'b0;
    @(posedge clk); #1;
    // Cycle 2: second entry; the skid variant parks it in the skid.
    a_in_data = 69'd2; a_in_ctrl = 4'd2;
    b_in_data = 69'd2; b_in_ctrl = 4'd2;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL fl_a_ready_stall got=%0d exp=0", a_in_ready); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL fl_b_ready_one got=%0d exp=1", b_in_ready); end
    @(posedge clk); #1;
    // Cycle 3: skid variant is FULL.
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL fl_b_ready_full got=%0d exp=0", b_in_ready); end
    @(posedge clk); #1;
    // Cycle 4: flush with a fresh offer and a willing downstream.
    a_flush = 1'b1; a_in_data = 69'd3; a_in_ctrl = 4'd3; a_out_ready = 1'b1;
    b_flush = 1'b1; b_in_data = 69'd3; b_in_ctrl = 4'd3; b_out_ready = 1'b1;
    @(posedge clk); #1;
    // Cycle 5: both stages must be empty bubbles.
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_ctrl = 4'hF;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_ctrl = 4'hF;
    #1;
    checks++; if ({a_out_valid, a_out_ctrl} !== 5'h00) begin errors++; $display("FAIL fl_a_bubble got=%0d/%0h exp=0/0", a_out_valid, a_out_ctrl); end
    checks++; if ({b_out_valid, b_out_ctrl} !== 5'h00) begin errors++; $display("FAIL fl_b_bubble got=%0d/%0h exp=0/0", b_out_valid, b_out_ctrl); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fl_a_ready got=%0d exp=1", a_in_ready); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL fl_b_ready got=%0d exp=1", b_in_ready); end
    checks++; if (a_stall_cnt !== 16'd2) begin errors++; $display("FAIL fl_a_stall got=%0d exp=2", a_stall_cnt); end
    checks++; if (b_stall_cnt !== 4'd2) begin errors++; $display("FAIL fl_b_stall got=%0d exp=2", b_stall_cnt); end
    @(posedge clk); #1;
    // Cycle 6: neither the flushed skid entry nor the flush-cycle offer shows up.
    a_in_valid = 1'b1; a_in_data = 69'd7; a_in_ctrl = 4'd7;
    b_in_valid = 1'b1; b_in_data = 69'd7; b_in_ctrl = 4'd7;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fl_a_ghost got=%0d exp=0", a_out_valid); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL fl_b_ghost got=%0d exp=0", b_out_valid); end
    @(posedge clk); #1;
    // Cycle 7: normal operation resumes with the new entry.
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    #1;
    checks++; if ({a_out_valid, a_out_ctrl, a_out_data} !== {1'b1, 4'd7, 69'd7}) begin errors++; $display("FAIL fl_a_resume got=%0d/%0h/%0d exp=1/7/7", a_out_valid, a_out_ctrl, a_out_data); end
    checks++; if ({b_out_valid, b_out_ctrl, b_out_data} !== {1'b1, 4'd7, 69'd7}) begin errors++; $display("FAIL fl_b_resume got=%0d/%0h/%0d exp=1/7/7", b_out_valid, b_out_ctrl, b_out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    do_reset();
    a_in_valid = 1'b1; a_in_data = 69'd9; a_in_ctrl = 4'd9;
    b_in_valid = 1'b1; b_in_data = 69'd9; b_in_ctrl = 4'd9;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 15 || i == 16 || i == 20) begin
        checks++; if (b_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_b_stall cyc=%0d got=%0d exp=15", i, b_stall_cnt); end
        checks++; if (a_stall_cnt !== 16'(i)) begin errors++; $display("FAIL sat_a_stall cyc=%0d got=%0d exp=%0d", i, a_stall_cnt, i); end
      end
    end
    checks++; if ({b_out_valid, b_out_data} !== {1'b1, 69'd9}) begin errors++; $display("FAIL sat_b_hold got=%0d/%0d exp=1/9", b_out_valid, b_out_data); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
